// File: rtl/bcd_entry_if.sv
// Keypad-to-operand bus for bcd_entry_ctrl: keypad strobes in, status and result out.
// dbg_state mirrors the controller FSM state for checkers.
interface bcd_entry_if;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        key_clr;
  logic        key_bs;
  logic        enter;
  logic        busy;
  logic [2:0]  digit_cnt;
  logic        key_err;
  logic [13:0] result;
  logic        result_valid;
  logic [1:0]  dbg_state;

  // Strobes are single-cycle requests with no ready path.
  // The keypad side may present them at any time.
  // While busy is high, key_valid, key_bs and enter are dropped;
  // key_clr is always honoured.
  modport master (
    output key_valid, key_digit, key_clr, key_bs, enter,
    input  busy, digit_cnt, key_err, result, result_valid, dbg_state
  );

  modport slave (
    input  key_valid, key_digit, key_clr, key_bs, enter,
    output busy, digit_cnt, key_err, result, result_valid, dbg_state
  );
endinterface

// File: rtl/bcd_entry_ctrl.sv
// Four-digit BCD operand entry with a sequential digit x weight conversion to 14-bit binary.
// Optional backspace support is enabled by defining BCD_ENTRY_BACKSPACE_EN.
module bcd_entry_ctrl #(
  parameter int MAX_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  bcd_entry_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [3:0][3:0]  buf_q;
  logic [2:0]       cnt_q;
  logic [1:0]       idx_q;
  logic [13:0]      prod_q;
  logic [13:0]      acc_q;
  logic [13:0]      result_q;
  logic             busy_q;
  logic             key_err_q;
  logic             result_valid_q;

  logic [13:0]      weight_d;
  logic [13:0]      prod_d;
  logic [13:0]      sum_d;

  always_comb begin
    weight_d = 14'd1;
    case (idx_q)
      2'd3:    weight_d = 14'd1000;
      2'd2:    weight_d = 14'd100;
      2'd1:    weight_d = 14'd10;
      default: weight_d = 14'd1;
    endcase
  end

  assign prod_d = {10'd0, buf_q[idx_q]} * weight_d;
  assign sum_d  = acc_q + prod_q;

`ifndef BCD_ENTRY_BACKSPACE_EN
  logic unused_key_bs;
  assign unused_key_bs = bus.key_bs;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      buf_q          <= '0;
      cnt_q          <= '0;
      idx_q          <= '0;
      prod_q         <= '0;
      acc_q          <= '0;
      result_q       <= '0;
      busy_q         <= 1'b0;
      key_err_q      <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      key_err_q      <= 1'b0;
      result_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.key_clr) begin
            buf_q <= '0;
            cnt_q <= '0;
          end else if (bus.enter) begin
            state_q <= S_ISSUE;
            idx_q   <= 2'd3;
            acc_q   <= '0;
            busy_q  <= 1'b1;
`ifdef BCD_ENTRY_BACKSPACE_EN
          end else if (bus.key_bs) begin
            if (cnt_q != 3'd0) begin
              buf_q <= {4'd0, buf_q[3:1]};
              cnt_q <= cnt_q - 3'd1;
            end else begin
              key_err_q <= 1'b1;
            end
`endif
          end else if (bus.key_valid) begin
            if (bus.key_digit > 4'd9 || cnt_q == 3'(MAX_DIGITS)) begin
              key_err_q <= 1'b1;
            end else begin
              buf_q <= {buf_q[2:0], bus.key_digit};
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end

        S_ISSUE: begin
          if (bus.key_clr) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            buf_q   <= '0;
            cnt_q   <= '0;
          end else begin
            prod_q <= prod_d;
            // The first product load has nothing valid in prod_q to add yet.
            if (idx_q != 2'd3) acc_q <= sum_d;
            if (idx_q == 2'd0) state_q <= S_DRAIN;
            else               idx_q   <= idx_q - 2'd1;
          end
        end

        S_DRAIN: begin
          if (bus.key_clr) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            buf_q   <= '0;
            cnt_q   <= '0;
          end else begin
            acc_q          <= sum_d;
            result_q       <= sum_d;
            result_valid_q <= 1'b1;
            state_q        <= S_DONE;
          end
        end

        default: begin
          // S_DONE: the buffer is cleared on exit whether or not key_clr is seen.
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          buf_q   <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.digit_cnt    = cnt_q;
  assign bus.key_err      = key_err_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_bcd_entry_ctrl.sv
// Directed bench for bcd_entry_ctrl: entry, conversion latency, key errors, abort and reset.
module tb_bcd_entry_ctrl;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  bcd_entry_if bus ();

  bcd_entry_ctrl #(.MAX_DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic key(input logic [3:0] d);
    bus.key_valid = 1'b1;
    bus.key_digit = d;
    tick();
    bus.key_valid = 1'b0;
  endtask

  // enter sampled at E0; result_valid high between E5 and E6; idle after E6.
  task automatic convert(input string tag, input logic [13:0] exp);
    bus.enter = 1'b1;
    tick();
    bus.enter = 1'b0;
    check({tag, "_busy_e0"}, bus.busy, 1);
    repeat (4) tick();
    check({tag, "_rv_e4"}, bus.result_valid, 0);
    tick();
    check({tag, "_rv_e5"}, bus.result_valid, 1);
    check({tag, "_result"}, bus.result, exp);
    check({tag, "_busy_e5"}, bus.busy, 1);
    tick();
    check({tag, "_rv_e6"}, bus.result_valid, 0);
    check({tag, "_busy_e6"}, bus.busy, 0);
    check({tag, "_cnt_e6"}, bus.digit_cnt, 0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_digit = 4'd0;
    bus.key_clr   = 1'b0;
    bus.key_bs    = 1'b0;
    bus.enter     = 1'b0;
    repeat (3) tick();
    check("rst_busy", bus.busy, 0);
    check("rst_cnt", bus.digit_cnt, 0);
    check("rst_err", bus.key_err, 0);
    check("rst_result", bus.result, 0);
    check("rst_rv", bus.result_valid, 0);
    rst_n = 1'b1;
    tick();

    // 1,2,3,4 -> 1234
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    check("t1_cnt4", bus.digit_cnt, 4);
    convert("t1", 14'd1234);

    // 7,5 -> 75, then empty buffer -> 0
    key(4'd7); key(4'd5);
    check("t2_cnt2", bus.digit_cnt, 2);
    convert("t2", 14'd75);
    convert("t2_empty", 14'd0);

    // Fifth digit rejected
    key(4'd9); key(4'd9); key(4'd9); key(4'd9);
    check("t3_err_none", bus.key_err, 0);
    key(4'd9);
    check("t3_err_full", bus.key_err, 1);
    check("t3_cnt_full", bus.digit_cnt, 4);
    tick();
    check("t3_err_pulse", bus.key_err, 0);
    convert("t3", 14'd9999);

    // Non-BCD digit rejected, buffer unchanged
    key(4'd1);
    key(4'hA);
    check("t3_err_hex", bus.key_err, 1);
    check("t3_cnt_hex", bus.digit_cnt, 1);
    convert("t3_hex", 14'd1);

    // Abort with key_clr during ISSUE
    key(4'd4); key(4'd2);
    bus.enter = 1'b1;
    tick();
    bus.enter = 1'b0;
    tick(); tick();
    bus.key_clr = 1'b1;
    tick();
    bus.key_clr = 1'b0;
    check("t4_busy", bus.busy, 0);
    check("t4_cnt", bus.digit_cnt, 0);
    check("t4_rv", bus.result_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_rv_after", bus.result_valid, 0);
    end
    check("t4_result_kept", bus.result, 1);

    // enter with key_valid in the same cycle, key_valid held while busy
    key(4'd3);
    bus.enter     = 1'b1;
    bus.key_valid = 1'b1;
    bus.key_digit = 4'd7;
    tick();
    bus.enter = 1'b0;
    check("t5_err_e0", bus.key_err, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_err_busy", bus.key_err, 0);
    end
    check("t5_result", bus.result, 3);
    tick();
    bus.key_valid = 1'b0;
    check("t5_cnt", bus.digit_cnt, 0);
    check("t5_busy", bus.busy, 0);

    // Reset mid-ISSUE
    key(4'd6);
    bus.enter = 1'b1;
    tick();
    bus.enter = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("t6_busy", bus.busy, 0);
    check("t6_cnt", bus.digit_cnt, 0);
    check("t6_result", bus.result, 0);
    check("t6_rv", bus.result_valid, 0);
    check("t6_err", bus.key_err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    key(4'd8);
    convert("t6", 14'd8);

`ifdef BCD_ENTRY_BACKSPACE_EN
    key(4'd5); key(4'd6); key(4'd7);
    bus.key_bs = 1'b1;
    tick();
    bus.key_bs = 1'b0;
    check("t7_bs_cnt", bus.digit_cnt, 2);
    check("t7_bs_err", bus.key_err, 0);
    key(4'd1);
    convert("t7", 14'd561);
    bus.key_bs = 1'b1;
    tick();
    bus.key_bs = 1'b0;
    check("t7_bs_empty_err", bus.key_err, 1);
    check("t7_bs_empty_cnt", bus.digit_cnt, 0);
`else
    key(4'd5); key(4'd6);
    bus.key_bs = 1'b1;
    tick();
    bus.key_bs = 1'b0;
    check("t7_bs_ign_cnt", bus.digit_cnt, 2);
    check("t7_bs_ign_err", bus.key_err, 0);
    convert("t7", 14'd56);
    bus.key_bs = 1'b1;
    tick();
    bus.key_bs = 1'b0;
    check("t7_bs_empty_err", bus.key_err, 0);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
